irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Bus-mapped priority interrupt controller on the CPU I/O bus, alongside the onboard devices.
- Collects up to 8 interrupt requests (timer, UART, keys, ...) and drives the single CPU IRQ line.
- Tracks pending and in-service state, so nested interrupts follow fixed priority (source 0 highest).
- The CPU reads a vector register to acknowledge, then writes EOI when the handler finishes.

Parameters:
- NSRC, 8, number of request inputs (1..8); register bits at index NSRC and above read 0 and ignore writes.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous reset, active-low
- AD  in  3  register address
- DI  in  8  write data
- DO  out  8  read data, registered
- rw  in  1  1=read, 0=write
- cs  in  1  chip select, one access per cycle while high
- irq_in  in  NSRC  request lines, active-high
- irq  out  1  interrupt to CPU, active-high, registered

Behaviour:
- Reset (rst low, async): DO=0, irq=0, pending=0, mask=0, mode=0, ISR=0, GIE=0, prev-sample=0, synchronizers=0.
- Register map:
  - $0 R pending; W write-1-to-clear edge-pending bits.
  - $1 RW mask (1=enabled).
  - $2 RW mode (1=edge, 0=level).
  - $3 R vector/acknowledge; writes ignored.
  - $4 R ISR; W any value = EOI.
  - $5 RW control: bit0 GIE. Reads return {irq, 6'b0, GIE}.
  - $6 R sampled irq_in.
  - $7 reads 0.
- Reads: DO is loaded on the clock edge where cs&rw, giving 1-cycle latency. DO holds its value otherwise.
- Sampling: s = irq_in, or the synchronized version when the optional feature is enabled.
- Level source: pending[i] = s[i] every cycle; W1C has no effect.
- Edge source: pending[i] sets when s[i]=1 and prev[i]=0. prev is updated every cycle.
- Mode write edge->level or level->edge: pending bit is cleared that cycle. The new-mode rule applies from the next cycle.
- Candidate: lowest index i with pending[i] & mask[i].
- Eligible: a candidate exists and its index is lower than the lowest set ISR bit (ISR=0 counts as index 8).
- irq <= GIE & eligible, updated every cycle (1-cycle delay from the condition).
- Vector read ($3):
  - If eligible: DO = {1'b1, 4'b0, idx[2:0]}; ISR[idx] set; pending[idx] cleared if edge mode.
  - If not eligible: DO = 8'h00, no state change.
- EOI ($4 write): clears the lowest set ISR bit. If ISR=0, no effect.
- Simultaneous events:
  - New edge in the same cycle as W1C or ack-clear of the same bit: set wins.
  - Vector read and mask write in the same cycle: mask before the write decides eligibility.
- Nesting: a higher-priority source interrupts a lower one in service. Equal or lower priority waits for EOI.
- irq drops the cycle after ack if no other source is eligible.
- Masked pending bits are retained and raise irq once unmasked.

Optional Feature:
- IRQ_SYNC_EN defined: each irq_in passes through a 2-flop synchronizer before edge detect and level sampling. This adds 2 cycles of latency and permits sources on other clocks (e.g. the timer clock).
- Undefined: irq_in is sampled directly, and sources must be synchronous to clk.

Test Plan:
- Reset mid-operation: pending=8'h05, ISR=8'h01, irq=1, then assert rst low -> all registers read 0, irq=0 immediately.
- Edge mode, mask=8'h08, GIE=1, pulse irq_in[3] -> irq=1; read $3 -> 8'h83, ISR=8'h08, pending[3]=0, irq=0 next cycle.
- Nesting: source 3 in service; pulse irq_in[1] -> irq=1, vector 8'h81, ISR=8'h0A. Pulse irq_in[5] -> irq stays 0. Two EOIs -> ISR 8'h08 then 8'h00, then irq=1 with vector 8'h85.
- Level mode: hold irq_in[0]=1, mask bit0, GIE=1 -> vector 8'h80, EOI, irq reasserts. Drop irq_in[0] -> pending=0, vector read 8'h00.
- Collision: write $0=8'h04 in the same cycle as a rising edge on irq_in[2] (edge mode) -> pending[2] stays 1.
- GIE=0 with pending & mask nonzero -> irq=0, $5 reads 8'h00. Set GIE -> irq=1 next cycle, $5 reads 8'h81.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// CPU I/O bus port of the interrupt controller.
// One register access per cycle while cs is high; DO is registered by the slave.
interface irq_ctrl_if;
  logic [2:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;

  modport master (output AD, output DI, output rw, output cs, input DO);
  modport slave  (input AD, input DI, input rw, input cs, output DO);
endinterface

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller (source 0 highest) with pending, mask, edge/level mode and in-service tracking.
// Define IRQ_SYNC_EN to pass each irq_in line through a 2-flop synchronizer before sampling.
module irq_ctrl #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  irq_ctrl_if.slave       bus,
  input  logic [NSRC-1:0] irq_in,
  output logic            irq
);

  localparam logic [7:0] VALID = 8'((9'd1 << NSRC) - 9'd1);

  logic [7:0] pend_q, pend_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] mode_q, mode_d;
  logic [7:0] isr_q,  isr_d;
  logic [7:0] prev_q, prev_d;
  logic [7:0] do_q,   do_d;
  logic       gie_q,  gie_d;
  logic       irq_q,  irq_d;

  logic [7:0] s_in;
  logic [7:0] samp;

  assign s_in = 8'(irq_in);

`ifdef IRQ_SYNC_EN
  logic [7:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 8'd0;
      sync2_q <= 8'd0;
    end else begin
      sync1_q <= s_in & VALID;
      sync2_q <= sync1_q;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = s_in & VALID;
`endif

  logic rd_en, wr_en;
  logic wr_pend, wr_mask, wr_mode, wr_eoi, wr_ctrl, rd_vec;

  assign rd_en   = bus.cs & bus.rw;
  assign wr_en   = bus.cs & ~bus.rw;
  assign wr_pend = wr_en & (bus.AD == 3'd0);
  assign wr_mask = wr_en & (bus.AD == 3'd1);
  assign wr_mode = wr_en & (bus.AD == 3'd2);
  assign wr_eoi  = wr_en & (bus.AD == 3'd4);
  assign wr_ctrl = wr_en & (bus.AD == 3'd5);
  assign rd_vec  = rd_en & (bus.AD == 3'd3);

  logic [7:0] act;
  logic       cand_vld;
  logic [2:0] cand_idx;
  logic       isr_vld;
  logic [2:0] isr_idx;
  logic [3:0] isr_lvl;
  logic       eligible;

  assign act = pend_q & mask_q;

  // Scan from the top so the lowest set index is the one left standing.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = 3'd0;
    isr_vld  = 1'b0;
    isr_idx  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (act[i]) begin
        cand_vld = 1'b1;
        cand_idx = 3'(i);
      end
      if (isr_q[i]) begin
        isr_vld = 1'b1;
        isr_idx = 3'(i);
      end
    end
  end

  assign isr_lvl  = isr_vld ? {1'b0, isr_idx} : 4'd8;
  assign eligible = cand_vld & ({1'b0, cand_idx} < isr_lvl);

  logic [7:0] ack_bit, eoi_bit;
  logic [7:0] rise, clr, mode_chg;

  assign ack_bit  = (rd_vec & eligible) ? (8'd1 << cand_idx) : 8'd0;
  assign eoi_bit  = (wr_eoi & isr_vld) ? (8'd1 << isr_idx) : 8'd0;
  assign rise     = samp & ~prev_q;
  assign clr      = (wr_pend ? bus.DI : 8'd0) | ack_bit;
  assign mode_chg = wr_mode ? (bus.DI ^ mode_q) : 8'd0;

  always_comb begin
    pend_d = pend_q;
    mask_d = mask_q;
    mode_d = mode_q;
    isr_d  = isr_q;
    gie_d  = gie_q;
    prev_d = samp;
    do_d   = do_q;
    irq_d  = gie_q & eligible;

    // Edge bits: a new rising edge beats any clear; level bits follow the input.
    pend_d = (mode_q & (rise | (pend_q & ~clr))) | (~mode_q & samp);
    pend_d = pend_d & ~mode_chg & VALID;

    isr_d = (isr_q | ack_bit) & ~eoi_bit;

    if (wr_mask) mask_d = bus.DI & VALID;
    if (wr_mode) mode_d = bus.DI & VALID;
    if (wr_ctrl) gie_d  = bus.DI[0];

    if (rd_en) begin
      case (bus.AD)
        3'd0:    do_d = pend_q;
        3'd1:    do_d = mask_q;
        3'd2:    do_d = mode_q;
        3'd3:    do_d = eligible ? {5'b10000, cand_idx} : 8'h00;
        3'd4:    do_d = isr_q;
        3'd5:    do_d = {irq_q, 6'b000000, gie_q};
        3'd6:    do_d = samp;
        default: do_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= 8'd0;
      mask_q <= 8'd0;
      mode_q <= 8'd0;
      isr_q  <= 8'd0;
      prev_q <= 8'd0;
      do_q   <= 8'd0;
      gie_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
      mode_q <= mode_d;
      isr_q  <= isr_d;
      prev_q <= prev_d;
      do_q   <= do_d;
      gie_q  <= gie_d;
      irq_q  <= irq_d;
    end
  end

  assign bus.DO = do_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus random bus/request traffic,
// every cycle compared against a rule-level model of the controller.
module tb_irq_ctrl;
  localparam int NSRC = 8;
`ifdef IRQ_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NSRC-1:0] irq_in = '0;
  logic            irq;

  irq_ctrl_if bus ();

  irq_ctrl #(.NSRC(NSRC)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .irq_in (irq_in),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state, kept as plain bit vectors indexed by source number.
  bit [7:0] m_pend, m_mask, m_mode, m_isr, m_prev, m_do, m_s1, m_s2;
  bit       m_gie, m_irq;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%02h exp=%02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_mask = 0; m_mode = 0; m_isr = 0; m_prev = 0;
    m_do = 0; m_s1 = 0; m_s2 = 0; m_gie = 0; m_irq = 0;
  endtask

  task automatic model_step();
    int       cand, lvl;
    bit       elig, rd, wr, acked, w1c;
    bit [7:0] s, n_pend, n_isr;
    cand = 8;
    lvl  = 8;
`ifdef IRQ_SYNC_EN
    s = m_s2;
`else
    s = 8'(irq_in);
`endif
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (m_pend[i] && m_mask[i]) cand = i;
      if (m_isr[i]) lvl = i;
    end
    elig = (cand < lvl);
    rd = bus.cs && bus.rw;
    wr = bus.cs && !bus.rw;

    if (rd) begin
      case (bus.AD)
        3'd0: m_do = m_pend;
        3'd1: m_do = m_mask;
        3'd2: m_do = m_mode;
        3'd3: m_do = elig ? 8'(8'h80 + cand) : 8'h00;
        3'd4: m_do = m_isr;
        3'd5: m_do = m_irq ? 8'h80 + 8'(m_gie) : 8'(m_gie);
        3'd6: m_do = s;
        default: m_do = 8'h00;
      endcase
    end

    n_pend = 0;
    for (int i = 0; i < NSRC; i++) begin
      acked = rd && bus.AD == 3'd3 && elig && cand == i;
      w1c   = wr && bus.AD == 3'd0 && bus.DI[i];
      if (wr && bus.AD == 3'd2 && bus.DI[i] != m_mode[i]) n_pend[i] = 0;
      else if (!m_mode[i])                                n_pend[i] = s[i];
      else if (s[i] && !m_prev[i])                        n_pend[i] = 1;
      else if (acked || w1c)                              n_pend[i] = 0;
      else                                                n_pend[i] = m_pend[i];
    end

    n_isr = m_isr;
    if (rd && bus.AD == 3'd3 && elig) n_isr[cand] = 1;
    if (wr && bus.AD == 3'd4 && lvl < 8) n_isr[lvl] = 0;

    m_irq  = m_gie && elig;
    m_pend = n_pend;
    m_isr  = n_isr;
    if (wr && bus.AD == 3'd1) m_mask = bus.DI;
    if (wr && bus.AD == 3'd2) m_mode = bus.DI;
    if (wr && bus.AD == 3'd5) m_gie  = bus.DI[0];
    m_prev = s;
    m_s2 = m_s1;
    m_s1 = 8'(irq_in);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    #1;
    chk("irq", {7'd0, irq}, {7'd0, m_irq});
    chk("do", bus.DO, m_do);
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.rw = 1'b0; bus.AD = a; bus.DI = d;
    tick();
    bus.cs = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
    bus.cs = 1'b1; bus.rw = 1'b1; bus.AD = a;
    tick();
    bus.cs = 1'b0;
    d = bus.DO;
  endtask

  task automatic rand_phase(input int n);
    for (int k = 0; k < n; k++) begin
      irq_in = irq_in ^ NSRC'($urandom & $urandom & $urandom);
      bus.cs = 1'($urandom_range(0, 1));
      bus.rw = 1'($urandom_range(0, 1));
      bus.AD = 3'($urandom);
      bus.DI = 8'($urandom);
      tick();
    end
    bus.cs = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    bus.cs = 1'b0; bus.rw = 1'b1; bus.AD = 3'd0; bus.DI = 8'd0;
    model_reset();
    repeat (2) tick();
    rst = 1'b1;

    for (int a = 0; a < 8; a++) begin
      bus_rd(3'(a), d);
      chk("reset_reg", d, 8'h00);
    end

    // Single edge source 3
    bus_wr(3'd2, 8'h08);
    bus_wr(3'd1, 8'h08);
    bus_wr(3'd5, 8'h01);
    irq_in[3] = 1'b1; tick(); irq_in[3] = 1'b0;
    repeat (1 + SL) tick();
    chk("edge_irq", {7'd0, irq}, 8'h01);
    bus_rd(3'd3, d); chk("edge_vec", d, 8'h83);
    tick();
    chk("edge_irq_drop", {7'd0, irq}, 8'h00);
    bus_rd(3'd4, d); chk("edge_isr", d, 8'h08);
    bus_rd(3'd0, d); chk("edge_pend", d, 8'h00);

    // Nesting: 1 preempts 3, 5 waits
    bus_wr(3'd2, 8'h2A);
    bus_wr(3'd1, 8'h2A);
    irq_in[1] = 1'b1; tick(); irq_in[1] = 1'b0;
    repeat (1 + SL) tick();
    chk("nest_irq", {7'd0, irq}, 8'h01);
    bus_rd(3'd3, d); chk("nest_vec1", d, 8'h81);
    bus_rd(3'd4, d); chk("nest_isr", d, 8'h0A);
    irq_in[5] = 1'b1; tick(); irq_in[5] = 1'b0;
    repeat (1 + SL) tick();
    chk("nest_low_wait", {7'd0, irq}, 8'h00);
    bus_wr(3'd4, 8'h00);
    bus_rd(3'd4, d); chk("nest_eoi1", d, 8'h08);
    bus_wr(3'd4, 8'h00);
    bus_rd(3'd4, d); chk("nest_eoi2", d, 8'h00);
    tick();
    chk("nest_irq5", {7'd0, irq}, 8'h01);
    bus_rd(3'd3, d); chk("nest_vec5", d, 8'h85);
    bus_wr(3'd4, 8'h00);

    // Level source 0
    bus_wr(3'd2, 8'h00);
    bus_wr(3'd1, 8'h01);
    irq_in[0] = 1'b1;
    repeat (2 + SL) tick();
    chk("lvl_irq", {7'd0, irq}, 8'h01);
    bus_rd(3'd3, d); chk("lvl_vec", d, 8'h80);
    repeat (2) tick();
    chk("lvl_inservice", {7'd0, irq}, 8'h00);
    bus_wr(3'd4, 8'h00);
    tick();
    chk("lvl_reassert", {7'd0, irq}, 8'h01);
    irq_in[0] = 1'b0;
    repeat (1 + SL) tick();
    bus_rd(3'd0, d); chk("lvl_drop_pend", d, 8'h00);
    bus_rd(3'd3, d); chk("lvl_drop_vec", d, 8'h00);

    // W1C colliding with a new edge on the same bit
    bus_wr(3'd1, 8'h00);
    bus_wr(3'd2, 8'h04);
    irq_in[2] = 1'b1;
    repeat (SL) tick();
    bus_wr(3'd0, 8'h04);
    bus_rd(3'd0, d); chk("collide_set_wins", d, 8'h04);
    bus_wr(3'd0, 8'h04);
    bus_rd(3'd0, d); chk("w1c_clears", d, 8'h00);
    irq_in[2] = 1'b0;

    // GIE gating
    bus_wr(3'd5, 8'h00);
    bus_wr(3'd1, 8'h04);
    irq_in[2] = 1'b1; tick(); irq_in[2] = 1'b0;
    repeat (1 + SL) tick();
    chk("gie_off_irq", {7'd0, irq}, 8'h00);
    bus_rd(3'd5, d); chk("gie_off_ctrl", d, 8'h00);
    bus_wr(3'd5, 8'h01);
    tick();
    chk("gie_on_irq", {7'd0, irq}, 8'h01);
    bus_rd(3'd5, d); chk("gie_on_ctrl", d, 8'h81);
    bus_rd(3'd3, d); chk("gie_vec", d, 8'h82);
    bus_wr(3'd4, 8'h00);

    rand_phase(3000);

    // Asynchronous reset in the middle of traffic
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_irq", {7'd0, irq}, 8'h00);
    chk("async_rst_do", bus.DO, 8'h00);
    irq_in = '0;
    repeat (2) tick();
    rst = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus_rd(3'(a), d);
      chk("midrst_reg", d, 8'h00);
    end

    rand_phase(600);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
